wdma_multi_ch: RTL and testbench

Parametrised multi-channel weight DMA for the MNIST accelerator. It streams weight words from the instruction/weight memory (ITCM) into NCH destination weight buffers, such as one conv buffer and several FC banks. Each channel has its own base address, length and enable. The block sits between the MNIST controller, which provides start, abort and configuration, and the accumulator weight RAMs. It supports configurable memory read latency and back-to-back channel transfers with no bubbles.

---
 rtl/wdma_multi_ch.sv | 224 ++++++++++++++++++++++
 tb/tb_wdma_multi_ch.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wdma_multi_ch.sv
// Multi-channel weight DMA: streams ITCM weight words into NCH destination buffers,
// channel after channel in ascending index order, through a fixed-latency read pipeline.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for i_start; config inputs are latched on start
// S_ISSUE | one memory read per cycle for the current channel
// S_DRAIN | reads finished; wait for in-flight words, then pulse o_done
module wdma_multi_ch #(
    parameter int DW     = 16,
    parameter int AW     = 16,
    parameter int NCH    = 5,
    parameter int RD_LAT = 1,
    parameter int CW     = $clog2(NCH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [NCH-1:0]    i_ch_en,
    input  logic [NCH*AW-1:0] i_ch_base,
    input  logic [NCH*AW-1:0] i_ch_len,
    output logic              o_mem_rd_en,
    output logic [AW-1:0]     o_mem_addr,
    input  logic [DW-1:0]     i_mem_data,
    output logic [NCH-1:0]    o_wr_en,
    output logic [AW-1:0]     o_wr_addr,
    output logic [DW-1:0]     o_wr_data,
    output logic [CW-1:0]     o_cur_ch,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_aborted,
    output logic [NCH-1:0]    o_ch_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Latched channel configuration
    logic [NCH-1:0] elig_q;
    logic [AW-1:0]  base_q [NCH];
    logic [AW-1:0]  len_q  [NCH];

    logic [CW-1:0]  cur_ch;
    logic [AW-1:0]  off_q;
    logic [AW-1:0]  addr_q;

    logic [NCH-1:0] elig_in;
    logic           first_found;
    logic [CW-1:0]  first_ch;
    logic           next_found;
    logic [CW-1:0]  next_ch;
    logic           last_off;
    logic [AW-1:0]  rd_addr;
    logic           rd_en;
    logic           done;
    logic           abort_now;
    logic           start_now;
    logic           pipe_empty;

    // Read tags travelling alongside the memory latency
    logic [RD_LAT-1:0] tag_v;
    logic [RD_LAT-1:0] tag_last;
    logic [CW-1:0]     tag_ch  [RD_LAT];
    logic [AW-1:0]     tag_off [RD_LAT];
    logic              wr_last_q;

    // Channel selection: lowest eligible index wins
    always_comb begin
        elig_in     = '0;
        first_found = 1'b0;
        first_ch    = '0;
        next_found  = 1'b0;
        next_ch     = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            elig_in[k] = i_ch_en[k] && (i_ch_len[k*AW +: AW] != '0);
            if (elig_in[k]) begin
                first_found = 1'b1;
                first_ch    = CW'(k);
            end
            if (elig_q[k] && (k > int'(cur_ch))) begin
                next_found = 1'b1;
                next_ch    = CW'(k);
            end
        end
    end

    assign rd_addr    = base_q[cur_ch] + off_q;
    assign last_off   = (off_q == (len_q[cur_ch] - AW'(1)));
    assign pipe_empty = ~|tag_v && ~|o_wr_en;
    assign abort_now  = i_abort && (state != S_IDLE);
    assign start_now  = i_start && (state == S_IDLE);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_nxt = first_found ? S_ISSUE : S_DRAIN;
                end
            end
            S_ISSUE: begin
                if (i_abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    rd_en = 1'b1;
                    if (last_off && !next_found) begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (i_abort) begin
                    state_nxt = S_IDLE;
                end else if (pipe_empty) begin
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign o_mem_rd_en = rd_en;
    assign o_mem_addr  = rd_en ? rd_addr : addr_q;
    assign o_busy      = (state != S_IDLE);
    assign o_done      = done;
    assign o_cur_ch    = cur_ch;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            elig_q    <= '0;
            cur_ch    <= '0;
            off_q     <= '0;
            addr_q    <= '0;
            tag_v     <= '0;
            tag_last  <= '0;
            wr_last_q <= 1'b0;
            o_wr_en   <= '0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
            o_aborted <= 1'b0;
            o_ch_done <= '0;
            for (int k = 0; k < NCH; k++) begin
                base_q[k] <= '0;
                len_q[k]  <= '0;
            end
            for (int k = 0; k < RD_LAT; k++) begin
                tag_ch[k]  <= '0;
                tag_off[k] <= '0;
            end
        end else begin
            o_aborted <= abort_now;

            if (start_now) begin
                elig_q <= elig_in;
                cur_ch <= first_ch;
                off_q  <= '0;
                for (int k = 0; k < NCH; k++) begin
                    base_q[k] <= i_ch_base[k*AW +: AW];
                    len_q[k]  <= i_ch_len[k*AW +: AW];
                end
            end else if (rd_en) begin
                addr_q <= rd_addr;
                if (!last_off) begin
                    off_q <= off_q + AW'(1);
                end else if (next_found) begin
                    cur_ch <= next_ch;
                    off_q  <= '0;
                end
            end

            for (int k = RD_LAT - 1; k > 0; k--) begin
                tag_v[k]    <= tag_v[k-1];
                tag_last[k] <= tag_last[k-1];
                tag_ch[k]   <= tag_ch[k-1];
                tag_off[k]  <= tag_off[k-1];
            end
            tag_v[0]    <= rd_en;
            tag_last[0] <= rd_en && last_off;
            tag_ch[0]   <= cur_ch;
            tag_off[0]  <= off_q;
            if (abort_now) begin
                tag_v <= '0;
            end

            // Write port is registered and forced to zero for invalid tags
            if (tag_v[RD_LAT-1] && !abort_now) begin
                o_wr_en   <= NCH'(1) << tag_ch[RD_LAT-1];
                o_wr_addr <= tag_off[RD_LAT-1];
                o_wr_data <= i_mem_data;
                wr_last_q <= tag_last[RD_LAT-1];
            end else begin
                o_wr_en   <= '0;
                o_wr_addr <= '0;
                o_wr_data <= '0;
                wr_last_q <= 1'b0;
            end

            if (start_now) begin
                o_ch_done <= '0;
            end else if (wr_last_q) begin
                o_ch_done <= o_ch_done | o_wr_en;
            end
        end
    end

endmodule

// File: tb/tb_wdma_multi_ch.sv
// Directed bench for wdma_multi_ch: one instance at RD_LAT=1 and one at RD_LAT=3,
// each fed by a memory model returning addr^16'hA5A5 after the configured latency.
module tb_wdma_multi_ch;
    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int NCH = 5;
    localparam int CW  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start1, start3, abort;
    logic [NCH-1:0]    en1, en3;
    logic [NCH*AW-1:0] base1, len1, base3, len3;

    logic           rd1, busy1, done1, abt1;
    logic [AW-1:0]  addr1, waddr1;
    logic [DW-1:0]  mdata1, wdata1;
    logic [NCH-1:0] wr1, chd1;
    logic [CW-1:0]  cur1;

    logic           rd3, busy3, done3, abt3;
    logic [AW-1:0]  addr3, waddr3;
    logic [DW-1:0]  mdata3, wdata3, m3a, m3b;
    logic [NCH-1:0] wr3, chd3;
    logic [CW-1:0]  cur3;

    wdma_multi_ch #(.DW(DW), .AW(AW), .NCH(NCH), .RD_LAT(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_abort(abort),
        .i_ch_en(en1), .i_ch_base(base1), .i_ch_len(len1),
        .o_mem_rd_en(rd1), .o_mem_addr(addr1), .i_mem_data(mdata1),
        .o_wr_en(wr1), .o_wr_addr(waddr1), .o_wr_data(wdata1), .o_cur_ch(cur1),
        .o_busy(busy1), .o_done(done1), .o_aborted(abt1), .o_ch_done(chd1)
    );

    wdma_multi_ch #(.DW(DW), .AW(AW), .NCH(NCH), .RD_LAT(3)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start3), .i_abort(abort),
        .i_ch_en(en3), .i_ch_base(base3), .i_ch_len(len3),
        .o_mem_rd_en(rd3), .o_mem_addr(addr3), .i_mem_data(mdata3),
        .o_wr_en(wr3), .o_wr_addr(waddr3), .o_wr_data(wdata3), .o_cur_ch(cur3),
        .o_busy(busy3), .o_done(done3), .o_aborted(abt3), .o_ch_done(chd3)
    );

    always @(posedge clk) begin
        mdata1 <= addr1 ^ 16'hA5A5;
        m3a    <= addr3 ^ 16'hA5A5;
        m3b    <= m3a;
        mdata3 <= m3b;
    end

    int n_cmp = 0;
    int n_bad = 0;

    int n_rd, n_wr, n_done, n_abt, n_busy, n_junk;
    int rd_first, rd_last, wr_first, wr_last, done_cyc, abt_cyc, busy_last;
    logic [AW-1:0]  rd_log[$];
    logic [AW-1:0]  wa_log[$];
    logic [DW-1:0]  wd_log[$];
    logic [NCH-1:0] we_log[$];
    logic [NCH-1:0] wr_or, chd_end;
    logic [CW-1:0]  cur5;
    logic [AW-1:0]  addr_end;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input bit sel, input int k);
        logic           s_rd, s_busy, s_done, s_abt;
        logic [AW-1:0]  s_addr, s_waddr;
        logic [DW-1:0]  s_wdata;
        logic [NCH-1:0] s_wr, s_chd;
        logic [CW-1:0]  s_cur;
        if (sel) begin
            s_rd = rd3; s_busy = busy3; s_done = done3; s_abt = abt3; s_addr = addr3;
            s_waddr = waddr3; s_wdata = wdata3; s_wr = wr3; s_chd = chd3; s_cur = cur3;
        end else begin
            s_rd = rd1; s_busy = busy1; s_done = done1; s_abt = abt1; s_addr = addr1;
            s_waddr = waddr1; s_wdata = wdata1; s_wr = wr1; s_chd = chd1; s_cur = cur1;
        end
        if (s_rd) begin
            if (n_rd == 0) rd_first = k;
            rd_last = k;
            rd_log.push_back(s_addr);
            n_rd++;
        end
        if (|s_wr) begin
            if (n_wr == 0) wr_first = k;
            wr_last = k;
            we_log.push_back(s_wr);
            wa_log.push_back(s_waddr);
            wd_log.push_back(s_wdata);
            wr_or |= s_wr;
            n_wr++;
        end else if ((s_waddr != '0) || (s_wdata != '0)) begin
            n_junk++;
        end
        if (s_done) begin n_done++; done_cyc = k; end
        if (s_abt) begin n_abt++; abt_cyc = k; end
        if (s_busy) begin n_busy++; busy_last = k; end
        if (k == 5) cur5 = s_cur;
        chd_end  = s_chd;
        addr_end = s_addr;
    endtask

    // Start sampled at edge T; sample k is taken mid-cycle T+k. abort_at=0 pairs abort with start.
    task automatic run(input bit sel, input int ncyc, input int abort_at, input int restart_at);
        n_rd = 0; n_wr = 0; n_done = 0; n_abt = 0; n_busy = 0; n_junk = 0;
        rd_first = -1; rd_last = -1; wr_first = -1; wr_last = -1;
        done_cyc = -1; abt_cyc = -1; busy_last = -1;
        rd_log.delete(); wa_log.delete(); wd_log.delete(); we_log.delete();
        wr_or = '0; cur5 = '0;
        @(negedge clk);
        if (sel) start3 = 1'b1; else start1 = 1'b1;
        abort = (abort_at == 0);
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk);
            #1;
            abort = (k == abort_at);
            if (sel) start3 = (k == restart_at); else start1 = (k == restart_at);
            @(negedge clk);
            sample(sel, k);
        end
        abort = 1'b0; start1 = 1'b0; start3 = 1'b0;
    endtask

    task automatic set_cfg_full();
        en1   = 5'b11111;
        len1  = {16'd3, 16'd3, 16'd3, 16'd3, 16'd4};
        base1 = {16'd13, 16'd10, 16'd7, 16'd4, 16'd0};
    endtask

    // 16 contiguous words: ch0 offsets 0..3, then ch1..ch4 offsets 0..2
    task automatic check_full(input string tag);
        int ch, off;
        chk({tag, "_nrd"}, n_rd, 16);
        chk({tag, "_rdfirst"}, rd_first, 1);
        chk({tag, "_rdlast"}, rd_last, 16);
        for (int i = 0; i < 16; i++) chk($sformatf("%s_rdaddr%0d", tag, i), rd_log[i], i);
        chk({tag, "_nwr"}, n_wr, 16);
        for (int i = 0; i < 16; i++) begin
            ch  = (i < 4) ? 0 : 1 + (i - 4) / 3;
            off = (i < 4) ? i : (i - 4) % 3;
            chk($sformatf("%s_wr%0d", tag, i), {we_log[i], wa_log[i], wd_log[i]},
                {5'(1 << ch), 16'(off), 16'(i) ^ 16'hA5A5});
        end
        chk({tag, "_wrfirst"}, wr_first, 3);
        chk({tag, "_wrlast"}, wr_last, 18);
        chk({tag, "_donecyc"}, done_cyc, 19);
        chk({tag, "_ndone"}, n_done, 1);
        chk({tag, "_busylast"}, busy_last, 19);
        chk({tag, "_chdone"}, chd_end, 5'b11111);
        chk({tag, "_idlezero"}, n_junk, 0);
        chk({tag, "_addrhold"}, addr_end, 16'd15);
        chk({tag, "_cur5"}, cur5, 1);
        chk({tag, "_nabt"}, n_abt, 0);
    endtask

    initial begin
        rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; abort = 1'b0;
        set_cfg_full();
        en3 = 5'b00001; base3 = {64'd0, 16'hFFFE}; len3 = {64'd0, 16'd4};
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_ctrl", {rd1, done1, abt1, cur1, chd1, wr1}, '0);
        chk("rst_data", {addr1, waddr1, wdata1}, '0);
        chk("rst_dut3", {busy3, rd3, wr3, addr3, chd3}, '0);

        // All channels, RD_LAT=1
        run(0, 22, -1, -1);
        check_full("full");

        // Sparse enables, channel 2 zero length
        en1   = 5'b10101;
        len1  = {16'd2, 16'd3, 16'd0, 16'd3, 16'd2};
        base1 = {16'd200, 16'd50, 16'd150, 16'd60, 16'd100};
        run(0, 10, -1, -1);
        chk("sparse_nrd", n_rd, 4);
        chk("sparse_rd0", rd_log[0], 16'd100);
        chk("sparse_rd1", rd_log[1], 16'd101);
        chk("sparse_rd2", rd_log[2], 16'd200);
        chk("sparse_rd3", rd_log[3], 16'd201);
        chk("sparse_nwr", n_wr, 4);
        chk("sparse_wror", wr_or, 5'b10001);
        chk("sparse_wr2", {we_log[2], wa_log[2], wd_log[2]}, {5'b10000, 16'd0, 16'hA56D});
        chk("sparse_chdone", chd_end, 5'b10001);
        chk("sparse_donecyc", done_cyc, 7);

        // Nothing eligible
        en1 = 5'b00000;
        run(0, 5, -1, -1);
        chk("none_nrd", n_rd, 0);
        chk("none_nwr", n_wr, 0);
        chk("none_nbusy", n_busy, 1);
        chk("none_donecyc", done_cyc, 1);
        chk("none_ndone", n_done, 1);

        // RD_LAT=3 with address wrap
        run(1, 12, -1, -1);
        chk("lat3_nrd", n_rd, 4);
        chk("lat3_rd0", rd_log[0], 16'hFFFE);
        chk("lat3_rd1", rd_log[1], 16'hFFFF);
        chk("lat3_rd2", rd_log[2], 16'h0000);
        chk("lat3_rd3", rd_log[3], 16'h0001);
        chk("lat3_nwr", n_wr, 4);
        chk("lat3_wrfirst", wr_first, 5);
        chk("lat3_wr0", {we_log[0], wa_log[0], wd_log[0]}, {5'b00001, 16'd0, 16'h5A5B});
        chk("lat3_wr1", {we_log[1], wa_log[1], wd_log[1]}, {5'b00001, 16'd1, 16'h5A5A});
        chk("lat3_wr2", {we_log[2], wa_log[2], wd_log[2]}, {5'b00001, 16'd2, 16'hA5A5});
        chk("lat3_wr3", {we_log[3], wa_log[3], wd_log[3]}, {5'b00001, 16'd3, 16'hA5A4});
        chk("lat3_donecyc", done_cyc, 9);
        chk("lat3_chdone", chd_end, 5'b00001);

        // Abort two cycles after the third read
        set_cfg_full();
        run(0, 10, 5, -1);
        chk("abt_nrd", n_rd, 4);
        chk("abt_nwr", n_wr, 3);
        chk("abt_wrlast", wr_last, 5);
        chk("abt_nabt", n_abt, 1);
        chk("abt_abtcyc", abt_cyc, 6);
        chk("abt_ndone", n_done, 0);
        chk("abt_busylast", busy_last, 5);
        chk("abt_chdone", chd_end, 5'b00000);

        // Start with abort in IDLE: start wins
        run(0, 22, 0, -1);
        check_full("after_abt");

        // Synchronous reset mid-transfer
        run(0, 6, -1, -1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_busy", busy1, 1'b0);
        chk("midrst_ctrl", {rd1, done1, abt1, cur1, chd1, wr1}, '0);
        chk("midrst_data", {addr1, waddr1, wdata1}, '0);
        rst_n = 1'b1;

        // Clean run; a start pulse while busy must be ignored
        run(0, 22, -1, 5);
        check_full("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
